// File: rtl/sec_disp_drv_pkg.sv
// Shared constants, FSM state type and 7-segment patterns
// for the seconds-of-day display driver.
package sec_disp_drv_pkg;

    localparam int SEC_PER_DAY = 86400;
    localparam int SEC_PER_HR  = 3600;
    localparam int SEC_PER_MIN = 60;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HR,
        S_MN,
        S_DIG,
        S_DONE
    } conv_state_e;

    // Patterns are {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_DASH  = 7'b100_0000;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sec_disp_drv_scan.sv
// Six-digit multiplexed 7-segment scanner: divider, index,
// digit mux, decode, dp/error/blank and output polarity.
module seg7_scan
    import sec_disp_drv_pkg::*;
#(
    parameter int SCAN_DIV    = 25000,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd,
    input  logic        range_err,
    input  logic        blank,
    output logic [7:0]  seg,
    output logic [5:0]  dig_sel
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic DIG_INV = (DIG_ACT_LOW != 0);
    localparam logic [7:0] SEG_OFF = {8{SEG_INV}};
    localparam logic [5:0] DIG_OFF = {6{DIG_INV}};

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    dig_q, dig_d;
    logic [3:0]    nib;
    logic [6:0]    pat;
    logic          dp;

    always_comb begin
        div_d = div_q + DW'(1);
        idx_d = idx_q;
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    nib = bcd[3:0];
            3'd1:    nib = bcd[7:4];
            3'd2:    nib = bcd[11:8];
            3'd3:    nib = bcd[15:12];
            3'd4:    nib = bcd[19:16];
            3'd5:    nib = bcd[23:20];
            default: nib = 4'hF;
        endcase
    end

    always_comb begin
        pat   = range_err ? SEG_DASH : seg7_decode(nib);
        dp    = !range_err && (idx_q == 3'd2 || idx_q == 3'd4);
        seg_d = {dp, pat} ^ SEG_OFF;
        dig_d = (6'b00_0001 << idx_q) ^ DIG_OFF;
        if (blank) begin
            seg_d = SEG_OFF;
            dig_d = DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= 3'd0;
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_q;

endmodule

// File: rtl/sec_disp_drv.sv
// Seconds-of-day to HH:MM:SS BCD converter (iterative subtract)
// driving a multiplexed 6-digit 7-segment display.
module sec_disp_drv
    import sec_disp_drv_pkg::*;
#(
    parameter int SCAN_DIV    = 25000,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sec_in,
    input  logic        blank,
    output logic [7:0]  seg,
    output logic [5:0]  dig_sel,
    output logic [23:0] bcd_time,
    output logic        conv_done,
    output logic        range_err
);

    conv_state_e state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] last_q, last_d;
    logic [16:0] rem_q, rem_d;
    logic [4:0]  hr_q, hr_d;
    logic [5:0]  mn_q, mn_d;
    logic [3:0]  ht_q, ht_d;
    logic [3:0]  mt_q, mt_d;
    logic [3:0]  st_q, st_d;
    logic [23:0] bcd_q, bcd_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        rem_d   = rem_q;
        hr_d    = hr_q;
        mn_d    = mn_q;
        ht_d    = ht_q;
        mt_d    = mt_q;
        st_d    = st_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!valid_q || sec_in != last_q)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                rem_d  = sec_in[16:0];
                last_d = sec_in;
                hr_d   = '0;
                mn_d   = '0;
                ht_d   = '0;
                mt_d   = '0;
                st_d   = '0;
                if (sec_in >= 32'(SEC_PER_DAY)) begin
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HR;
                end
            end
            S_HR: begin
                if (rem_q >= 17'(SEC_PER_HR)) begin
                    rem_d = rem_q - 17'(SEC_PER_HR);
                    hr_d  = hr_q + 5'd1;
                end else begin
                    state_d = S_MN;
                end
            end
            S_MN: begin
                if (rem_q >= 17'(SEC_PER_MIN)) begin
                    rem_d = rem_q - 17'(SEC_PER_MIN);
                    mn_d  = mn_q + 6'd1;
                end else begin
                    state_d = S_DIG;
                end
            end
            S_DIG: begin
                // Hours, minutes and seconds split into tens/units in parallel
                if (hr_q < 5'd10 && mn_q < 6'd10 && rem_q < 17'd10)
                    state_d = S_DONE;
                if (hr_q >= 5'd10) begin
                    hr_d = hr_q - 5'd10;
                    ht_d = ht_q + 4'd1;
                end
                if (mn_q >= 6'd10) begin
                    mn_d = mn_q - 6'd10;
                    mt_d = mt_q + 4'd1;
                end
                if (rem_q >= 17'd10) begin
                    rem_d = rem_q - 17'd10;
                    st_d  = st_q + 4'd1;
                end
            end
            S_DONE: begin
                bcd_d   = {ht_q, hr_q[3:0], mt_q, mn_q[3:0], st_q, rem_q[3:0]};
                err_d   = 1'b0;
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= '0;
            rem_q   <= '0;
            hr_q    <= '0;
            mn_q    <= '0;
            ht_q    <= '0;
            mt_q    <= '0;
            st_q    <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            hr_q    <= hr_d;
            mn_q    <= mn_d;
            ht_q    <= ht_d;
            mt_q    <= mt_d;
            st_q    <= st_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bcd_time  = bcd_q;
    assign conv_done = done_q;
    assign range_err = err_q;

    seg7_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .SEG_ACT_LOW (SEG_ACT_LOW),
        .DIG_ACT_LOW (DIG_ACT_LOW)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd       (bcd_q),
        .range_err (err_q),
        .blank     (blank),
        .seg       (seg),
        .dig_sel   (dig_sel)
    );

endmodule

// File: tb/tb_sec_disp_drv.sv
// Directed bench for sec_disp_drv: conversion latency/values,
// range error, scan order/rate, blanking and mid-run reset.
module tb_sec_disp_drv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sec_in = '0;
    logic        blank = 1'b0;
    logic [7:0]  seg;
    logic [5:0]  dig_sel;
    logic [23:0] bcd_time;
    logic        conv_done;
    logic        range_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sec_disp_drv #(
        .SCAN_DIV    (4),
        .SEG_ACT_LOW (1),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_in    (sec_in),
        .blank     (blank),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .bcd_time  (bcd_time),
        .conv_done (conv_done),
        .range_err (range_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges from an input change (made at negedge) until conv_done is seen
    task automatic wait_done(input int bound, output int n);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            n++;
            if (conv_done) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        sec_in = 32'd0;
        tick();
        tick();
        n_cmp++;
        if ({bcd_time, conv_done, range_err} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_regs: got bcd=%h done=%b err=%b want 0", bcd_time, conv_done, range_err);
        end
        n_cmp++;
        if (seg !== 8'hFF || dig_sel !== 6'h3F) begin
            n_err++;
            $display("FAIL reset_disp: got seg=%h dig=%h want ff/3f", seg, dig_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(20, n);
        n_cmp++;
        if (n !== 6) begin
            n_err++;
            $display("FAIL reset_latency: got %0d edges want 6", n);
        end
        n_cmp++;
        if (bcd_time !== 24'h000000 || range_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_conv: got bcd=%h err=%b want 000000/0", bcd_time, range_err);
        end
        tick();
        n_cmp++;
        if (conv_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pulse_width: got conv_done=%b want 0", conv_done);
        end
    endtask

    task automatic test_max_time();
        int n;
        @(negedge clk);
        sec_in = 32'd86399;
        wait_done(150, n);
        n_cmp++;
        if (n !== 93) begin
            n_err++;
            $display("FAIL max_latency: got %0d edges want 93", n);
        end
        n_cmp++;
        if (bcd_time !== 24'h235959) begin
            n_err++;
            $display("FAIL max_bcd: got %h want 235959", bcd_time);
        end
    endtask

    task automatic test_scan_digits();
        logic [7:0] pat [6];
        logic [5:0] want_dig;
        logic [7:0] want_seg;
        bit         hit;
        pat[0] = 8'h6F;
        pat[1] = 8'h6D;
        pat[2] = 8'hEF;
        pat[3] = 8'h6D;
        pat[4] = 8'hCF;
        pat[5] = 8'h5B;
        for (int i = 0; i < 6; i++) begin
            want_dig = ~(6'b000001 << i);
            want_seg = ~pat[i];
            hit = 1'b0;
            for (int c = 0; c < 40 && !hit; c++) begin
                tick();
                if (dig_sel === want_dig) hit = 1'b1;
            end
            n_cmp++;
            if (!hit || seg !== want_seg) begin
                n_err++;
                $display("FAIL scan_digit%0d: got dig=%h seg=%h want dig=%h seg=%h", i, dig_sel, seg, want_dig, want_seg);
            end
        end
    endtask

    task automatic test_range_err();
        int pulses;
        int bad;
        int n;
        @(negedge clk);
        sec_in = 32'd86400;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (conv_done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL range_no_done: got %0d pulses want 0", pulses);
        end
        n_cmp++;
        if (range_err !== 1'b1 || bcd_time !== 24'h235959) begin
            n_err++;
            $display("FAIL range_flag: got err=%b bcd=%h want 1/235959", range_err, bcd_time);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (seg !== 8'hBF) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL range_dash: got %0d non-dash samples want 0", bad);
        end
        @(negedge clk);
        sec_in = 32'd59;
        wait_done(40, n);
        n_cmp++;
        if (n !== 11 || range_err !== 1'b0 || bcd_time !== 24'h000059) begin
            n_err++;
            $display("FAIL range_recover: got n=%0d err=%b bcd=%h want 11/0/000059", n, range_err, bcd_time);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int e1;
        int e2;
        logic [23:0] b1;
        logic [23:0] b2;
        pulses = 0;
        e1 = -1;
        e2 = -1;
        b1 = '0;
        b2 = '0;
        @(negedge clk);
        sec_in = 32'd45296;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (i == 10) sec_in = 32'd45297;
            if (conv_done) begin
                pulses++;
                if (pulses == 1) begin
                    e1 = i;
                    b1 = bcd_time;
                end else begin
                    e2 = i;
                    b2 = bcd_time;
                end
            end
        end
        n_cmp++;
        if (pulses !== 2) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d want 2", pulses);
        end
        n_cmp++;
        if (b1 !== 24'h123456 || e1 !== 57) begin
            n_err++;
            $display("FAIL b2b_first: got bcd=%h edge=%0d want 123456/57", b1, e1);
        end
        n_cmp++;
        if (b2 !== 24'h123457 || e2 !== 114) begin
            n_err++;
            $display("FAIL b2b_second: got bcd=%h edge=%0d want 123457/114", b2, e2);
        end
    endtask

    task automatic test_scan_rate();
        logic [5:0] prev;
        int         prev_idx;
        int         cur_idx;
        int         run;
        int         trans;
        int         bad;
        prev = dig_sel;
        prev_idx = -1;
        run = 0;
        trans = 0;
        bad = 0;
        for (int c = 0; c < 80 && trans < 9; c++) begin
            tick();
            run++;
            if (dig_sel !== prev) begin
                cur_idx = -1;
                for (int k = 0; k < 6; k++)
                    if (dig_sel === ~(6'b000001 << k)) cur_idx = k;
                if (prev_idx >= 0) begin
                    if (run != 4 || cur_idx != (prev_idx + 1) % 6) bad++;
                end
                prev_idx = cur_idx;
                prev = dig_sel;
                run = 0;
                trans++;
            end
        end
        n_cmp++;
        if (bad !== 0 || trans !== 9) begin
            n_err++;
            $display("FAIL scan_rate: got %0d bad steps in %0d transitions want 0/9", bad, trans);
        end
    endtask

    task automatic test_blank();
        @(negedge clk);
        blank = 1'b1;
        tick();
        n_cmp++;
        if (seg !== 8'hFF || dig_sel !== 6'h3F) begin
            n_err++;
            $display("FAIL blank_on: got seg=%h dig=%h want ff/3f", seg, dig_sel);
        end
        tick();
        tick();
        n_cmp++;
        if (seg !== 8'hFF || dig_sel !== 6'h3F) begin
            n_err++;
            $display("FAIL blank_hold: got seg=%h dig=%h want ff/3f", seg, dig_sel);
        end
        @(negedge clk);
        blank = 1'b0;
        tick();
        n_cmp++;
        if (dig_sel === 6'h3F || $countones(~dig_sel) !== 1) begin
            n_err++;
            $display("FAIL blank_off: got dig=%h want one low bit", dig_sel);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        sec_in = 32'd86399;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bcd_time !== 24'd0 || conv_done !== 1'b0 || range_err !== 1'b0 || seg !== 8'hFF || dig_sel !== 6'h3F) begin
            n_err++;
            $display("FAIL rst_mid: got bcd=%h done=%b err=%b seg=%h dig=%h want 0/0/0/ff/3f", bcd_time, conv_done, range_err, seg, dig_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(150, n);
        n_cmp++;
        if (n !== 93 || bcd_time !== 24'h235959) begin
            n_err++;
            $display("FAIL rst_reconv: got n=%0d bcd=%h want 93/235959", n, bcd_time);
        end
    endtask

    initial begin
        test_reset();
        test_max_time();
        test_scan_digits();
        test_range_err();
        test_back_to_back();
        test_scan_rate();
        test_blank();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
